// File: rtl/mac_array_acc.sv
// ---------------------------------------------------------------------------
// mac_array_acc
//   Multi-lane signed multiply-accumulate engine. Each accepted beat
//   multiplies LANES signed DW-bit data/weight pairs, sums the products and
//   accumulates that beat sum over a run-time frame of 1..2**LEN_W-1 beats.
//   One signed ACC_W-bit result is emitted per frame over a valid/ready
//   output.
//
//   Build option: define MAC_SAT_EN to saturate each accumulation step and
//   report a per-frame sticky overflow on ovf. Without it the accumulator
//   wraps at ACC_W bits and ovf is tied low.
//
// Ports
//   clk        clock, all state on rising edge
//   reset      synchronous, active-high
//   in_valid   beat present on data/weight
//   in_ready   block can accept a beat (= !out_valid || out_ready)
//   data       packed signed elements, lane i = data[i*DW +: DW]
//   weight     packed signed weights, same packing as data
//   frame_len  beats per frame, sampled on the first beat (0 means 1)
//   out_valid  result holds a completed frame sum
//   out_ready  consumer takes result
//   result     signed frame sum
//   ovf        frame saturated (MAC_SAT_EN only, otherwise 0)
// ---------------------------------------------------------------------------
module mac_array_acc #(
    parameter int LANES = 3,
    parameter int DW    = 8,
    parameter int ACC_W = 20,
    parameter int LEN_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   data,
    input  logic [LANES*DW-1:0]   weight,
    input  logic [LEN_W-1:0]      frame_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      result,
    output logic                  ovf
);

    localparam int PW = 2 * DW;

    // Per-lane signed products
    logic signed [PW-1:0] prod [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign prod[gi] = $signed(data[gi*DW +: DW]) * $signed(weight[gi*DW +: DW]);
        end
    endgenerate

    // Sum of all lanes, each product sign-extended to ACC_W first. ACC_W is
    // wide enough for the whole beat sum, so this never overflows; synthesis
    // is free to rebalance the chain into a tree.
    logic signed [ACC_W-1:0] tree_sum;

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + ACC_W'(prod[i]);
        end
    end

    // Frame state
    logic signed [ACC_W-1:0] acc_reg;
    logic [LEN_W-1:0]        count_reg;
    logic [LEN_W-1:0]        len_reg;
    logic                    open_reg;
    logic [ACC_W-1:0]        result_reg;
    logic                    out_valid_reg;

    logic                    accept;
    logic                    first_beat;
    logic [LEN_W-1:0]        len_eff;
    logic                    last_beat;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_next;

    assign in_ready  = !out_valid_reg || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;

    // The frame length is taken from the port only on the first beat; later
    // beats use the latched copy so mid-frame changes have no effect.
    assign first_beat = !open_reg;
    assign len_eff    = first_beat ? ((frame_len == '0) ? LEN_W'(1) : frame_len) : len_reg;
    assign last_beat  = (count_reg == len_eff - LEN_W'(1));
    assign acc_base   = first_beat ? '0 : acc_reg;

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;
    logic                  step_sat;
    logic                  frame_sat;
    logic                  sat_reg;
    logic                  ovf_reg;

    // One extra bit exposes signed overflow: the top two bits disagree.
    always_comb begin
        sum_wide  = {acc_base[ACC_W-1], acc_base} + {tree_sum[ACC_W-1], tree_sum};
        step_sat  = (sum_wide[ACC_W] != sum_wide[ACC_W-1]);
        acc_next  = sum_wide[ACC_W-1:0];
        if (step_sat) begin
            acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        // sat_reg is already clear whenever no frame is open
        frame_sat = sat_reg || step_sat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_reg <= 1'b0;
            ovf_reg <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                ovf_reg <= frame_sat;
                sat_reg <= 1'b0;
            end else begin
                sat_reg <= frame_sat;
            end
        end
    end

    assign ovf = ovf_reg;
`else
    assign acc_next = acc_base + tree_sum;
    assign ovf      = 1'b0;
`endif

    // Handshake release is evaluated first so that a frame completing on
    // the same edge keeps out_valid high with the new result.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg       <= '0;
            count_reg     <= '0;
            len_reg       <= '0;
            open_reg      <= 1'b0;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (accept) begin
                if (last_beat) begin
                    result_reg    <= acc_next;
                    out_valid_reg <= 1'b1;
                    acc_reg       <= '0;
                    count_reg     <= '0;
                    open_reg      <= 1'b0;
                end else begin
                    acc_reg   <= acc_next;
                    count_reg <= count_reg + LEN_W'(1);
                    len_reg   <= len_eff;
                    open_reg  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_array_acc.sv
// ---------------------------------------------------------------------------
// tb_mac_array_acc
//   Directed scenarios followed by randomized traffic, checked every cycle
//   against a frame-level reference model (queue of beat sums per frame).
// ---------------------------------------------------------------------------
module tb_mac_array_acc;

    localparam int LANES = 3;
    localparam int DW    = 8;
    localparam int ACC_W = 20;
    localparam int LEN_W = 4;

    localparam longint MAXV = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W - 1));
    localparam longint MODV = longint'(1) << ACC_W;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*DW-1:0]  data;
    logic [LANES*DW-1:0]  weight;
    logic [LEN_W-1:0]     frame_len;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     result;
    logic                 ovf;

    mac_array_acc #(
        .LANES(LANES), .DW(DW), .ACC_W(ACC_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .weight(weight), .frame_len(frame_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    // Reference model state
    longint beats[$];
    int     m_len    = 1;
    bit     m_valid  = 1'b0;
    longint m_result = 0;
    bit     m_ovf    = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [LANES*DW-1:0] pack3(input int a, input int b, input int c);
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] z;
        x = DW'(a);
        y = DW'(b);
        z = DW'(c);
        return {z, y, x};
    endfunction

    function automatic longint beat_sum(input logic [LANES*DW-1:0] d, input logic [LANES*DW-1:0] w);
        longint s = 0;
        for (int i = 0; i < LANES; i++) begin
            longint a = longint'($signed(d[i*DW +: DW]));
            longint b = longint'($signed(w[i*DW +: DW]));
            s += a * b;
        end
        return s;
    endfunction

    // Fold the collected beat sums into the frame result
    function automatic void close_frame();
        longint t = 0;
        bit     s = 1'b0;
        foreach (beats[i]) begin
            t += beats[i];
`ifdef MAC_SAT_EN
            if (t > MAXV) begin
                t = MAXV;
                s = 1'b1;
            end else if (t < MINV) begin
                t = MINV;
                s = 1'b1;
            end
`endif
        end
`ifndef MAC_SAT_EN
        t = t & (MODV - 1);
        if (t > MAXV) t -= MODV;
`endif
        m_result = t;
        m_ovf    = s;
        m_valid  = 1'b1;
        beats.delete();
    endfunction

    // One clock cycle: starts and ends at a falling edge
    task automatic cycle(input bit v, input logic [LANES*DW-1:0] d,
                         input logic [LANES*DW-1:0] w, input int fl, input bit rdy);
        bit     exp_ready;
        bit     acc;
        longint bs;
        in_valid  = v;
        data      = d;
        weight    = w;
        frame_len = LEN_W'(fl);
        out_ready = rdy;
        #1;
        exp_ready = !m_valid || rdy;
        check("in_ready", longint'(in_ready), longint'(exp_ready));
        acc = v && exp_ready;
        bs  = beat_sum(d, w);
        @(posedge clk);
        if (m_valid && rdy) begin
            m_valid = 1'b0;
            n_txn++;
            $display("txn %0d: result=%0d ovf=%0d", n_txn, m_result, m_ovf);
        end
        if (acc) begin
            if (beats.size() == 0) m_len = (fl % (1 << LEN_W) == 0) ? 1 : fl % (1 << LEN_W);
            beats.push_back(bs);
            if (beats.size() == m_len) close_frame();
        end
        @(negedge clk);
        check("out_valid", longint'(out_valid), longint'(m_valid));
        check("result", longint'($signed(result)), m_result);
        check("ovf", longint'(ovf), longint'(m_ovf));
    endtask

    task automatic do_reset(input bit v);
        reset    = 1'b1;
        in_valid = v;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        beats.delete();
        m_valid  = 1'b0;
        m_result = 0;
        m_ovf    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_result", longint'($signed(result)), 0);
        check("rst_ovf", longint'(ovf), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        @(negedge clk);
    endtask

    logic [LANES*DW-1:0] d1, w1, m128, p127, ones, z0;
    longint held;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        data = '0; weight = '0; frame_len = '0;
        z0   = '0;
        @(negedge clk);
        do_reset(1'b0);

        // Single frame of three identical beats
        d1 = pack3(1, 2, 3);
        w1 = pack3(4, 5, 6);
        cycle(1, d1, w1, 3, 1);
        cycle(1, d1, w1, 3, 1);
        check("t1_early_valid", longint'(out_valid), 0);
        cycle(1, d1, w1, 3, 1);
        check("t1_valid", longint'(out_valid), 1);
        check("t1_result", longint'($signed(result)), 96);
        cycle(0, z0, z0, 0, 1);

        // Signed extremes, L=1, second result replaces first on the same edge
        m128 = pack3(-128, -128, -128);
        p127 = pack3(127, 127, 127);
        cycle(1, m128, m128, 1, 1);
        check("t2_max_product", longint'($signed(result)), 49152);
        cycle(1, m128, p127, 1, 1);
        check("t2_mixed_valid", longint'(out_valid), 1);
        check("t2_mixed", longint'($signed(result)), -48768);
        cycle(0, z0, z0, 0, 1);

        // Backpressure
        cycle(1, pack3(5, 0, 0), pack3(1, 0, 0), 1, 0);
        held = 5;
        for (int i = 0; i < 5; i++) begin
            cycle(1, pack3(7, 7, 7), pack3(7, 7, 7), 2, 0);
            check("t3_stall_ready", longint'(in_ready), 0);
            check("t3_stable", longint'($signed(result)), held);
        end
        cycle(1, pack3(10, 0, 0), pack3(1, 0, 0), 2, 1);
        check("t3_released", longint'(out_valid), 0);
        cycle(1, pack3(20, 0, 0), pack3(1, 0, 0), 2, 1);
        check("t3_frame2", longint'($signed(result)), 30);
        cycle(0, z0, z0, 0, 1);

        // frame_len changes mid-frame are ignored
        cycle(1, d1, w1, 3, 1);
        cycle(1, d1, w1, 1, 1);
        check("t4_len_ignored", longint'(out_valid), 0);
        cycle(1, d1, w1, 1, 1);
        check("t4_len_close", longint'(out_valid), 1);
        // frame_len=0 behaves as 1
        for (int i = 1; i <= 3; i++) begin
            cycle(1, pack3(i, 0, 0), pack3(3, 0, 0), 0, 1);
            check("t4_len0_valid", longint'(out_valid), 1);
            check("t4_len0_result", longint'($signed(result)), 3 * i);
        end
        cycle(0, z0, z0, 0, 1);

        // Reset on beat 2 of a 3-beat frame
        ones = pack3(1, 1, 1);
        cycle(1, ones, ones, 3, 1);
        do_reset(1'b1);
        cycle(1, ones, ones, 3, 1);
        cycle(1, ones, ones, 3, 1);
        check("t5_no_stale", longint'(out_valid), 0);
        cycle(1, ones, ones, 3, 1);
        check("t5_result", longint'($signed(result)), 9);
        cycle(0, z0, z0, 0, 1);

        // Overflow across a 15-beat frame
        for (int i = 0; i < 15; i++) cycle(1, m128, m128, 15, 1);
        check("t6_valid", longint'(out_valid), 1);
`ifdef MAC_SAT_EN
        check("t6_result_sat", longint'($signed(result)), 524287);
        check("t6_ovf", longint'(ovf), 1);
`else
        check("t6_result_wrap", longint'($signed(result)), -311296);
        check("t6_ovf", longint'(ovf), 0);
`endif
        cycle(0, z0, z0, 0, 1);

        // Randomized traffic, with occasional extreme operands
        for (int i = 0; i < 600; i++) begin
            logic [LANES*DW-1:0] rd;
            logic [LANES*DW-1:0] rw;
            rd = ($urandom_range(0, 7) == 0) ? m128 : (LANES*DW)'($urandom);
            rw = ($urandom_range(0, 7) == 0) ? m128 : (LANES*DW)'($urandom);
            cycle($urandom_range(0, 3) != 0, rd, rw, $urandom_range(0, 15),
                  $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 3; i++) cycle(0, z0, z0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
